// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared definitions for the fpcvt streaming converter.
//   - width derivation helpers (magnitude width, max exponent, clog2, index width)
//   - parameter legality check
//   - fp_word_t {sign, exp, sig} packed struct and builder for the default widths
package fpcvt_pkg;

    localparam int unsigned DefInW     = 12;
    localparam int unsigned DefExpW    = 3;
    localparam int unsigned DefSigW    = 4;
    localparam int unsigned DefSatCntW = 16;

    function automatic int unsigned fp_mag_w(input int unsigned in_w);
        return in_w - 1;
    endfunction

    function automatic int unsigned fp_exp_max(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    function automatic int unsigned fp_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of a bit index into a vector of width w; never narrower than one bit.
    function automatic int unsigned fp_idx_w(input int unsigned w);
        return (fp_clog2(w) < 1) ? 1 : fp_clog2(w);
    endfunction

    function automatic bit fp_legal(input int unsigned in_w, input int unsigned exp_w,
                                    input int unsigned sig_w);
        if (in_w < 2 || exp_w < 1 || exp_w > 30 || sig_w < 1) return 1'b0;
        return fp_mag_w(in_w) <= sig_w + fp_exp_max(exp_w);
    endfunction

    typedef struct packed {
        logic               sign;
        logic [DefExpW-1:0] exp;
        logic [DefSigW-1:0] sig;
    } fp_word_t;

    function automatic fp_word_t fp_build(input logic sign, input logic [DefExpW-1:0] exp,
                                          input logic [DefSigW-1:0] sig);
        fp_word_t w;
        w.sign = sign;
        w.exp  = exp;
        w.sig  = sig;
        return w;
    endfunction

endpackage

// File: rtl/fpcvt_if.sv
// fpcvt_if: input and output valid/ready streams of the converter.
//   in_valid/in_ready/in_data           : sample stream into the converter
//   out_valid/out_ready/out_data/out_sat : float result stream out of the converter
// Modports: slave = converter side, master = source/sink side.
interface fpcvt_if #(
    parameter int unsigned IN_W  = fpcvt_pkg::DefInW,
    parameter int unsigned EXP_W = fpcvt_pkg::DefExpW,
    parameter int unsigned SIG_W = fpcvt_pkg::DefSigW
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [IN_W-1:0]          in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [EXP_W+SIG_W:0]     out_data;
    logic                     out_sat;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fpcvt_lod.sv
// fpcvt_lod: leading-one detector.
//   mag  in  MAG_W  vector to scan
//   idx  out IDX_W  index of the highest set bit (0 when mag is zero)
//   zero out 1      mag is all zeros
module fpcvt_lod #(
    parameter int unsigned MAG_W = 11,
    parameter int unsigned IDX_W = 4
) (
    input  logic [MAG_W-1:0] mag,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);
    always_comb begin
        idx = '0;
        // Ascending scan: the last hit is the most significant one.
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) idx = IDX_W'(i);
        end
        zero = ~|mag;
    end
endmodule

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: 3-stage streaming two's-complement -> {sign, exp, sig} float converter.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fpcvt_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_sat)
//   sat_count  : saturating count of saturated output transfers (FPCVT_SAT_CNT_EN only)
// Stages: S1 sign/magnitude, S2 leading-one normalise, S3 round/saturate/pack.
// Optional feature macro: FPCVT_SAT_CNT_EN adds the sat_count port and counter.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int unsigned IN_W     = DefInW,
    parameter int unsigned EXP_W    = DefExpW,
    parameter int unsigned SIG_W    = DefSigW,
    parameter int unsigned SATCNT_W = DefSatCntW
) (
    input logic     clk,
    input logic     rst_n,
    fpcvt_if.slave  bus
`ifdef FPCVT_SAT_CNT_EN
    ,
    output logic [SATCNT_W-1:0] sat_count
`endif
);
    localparam int unsigned MAG_W   = fp_mag_w(IN_W);
    localparam int unsigned EXP_MAX = fp_exp_max(EXP_W);
    localparam int unsigned IDX_W   = fp_idx_w(MAG_W);
    localparam int unsigned E_W     = IDX_W + 1;
    localparam int unsigned OUT_W   = 1 + EXP_W + SIG_W;
    localparam int unsigned X_W     = MAG_W + SIG_W;

    if (!fp_legal(IN_W, EXP_W, SIG_W) || SATCNT_W == 0) begin : g_bad_cfg
        $error("fpcvt_pipe: illegal parameter combination");
    end

    logic rdy1, rdy2, rdy3;
    logic v1_q, v2_q, v3_q;

    assign rdy3 = !v3_q || bus.out_ready;
    assign rdy2 = !v2_q || rdy3;
    assign rdy1 = !v1_q || rdy2;
    assign bus.in_ready = rdy1;

    // ---------------- S1: sign / magnitude ----------------
    logic [IN_W-1:0]  neg_s1;
    logic [MAG_W-1:0] mag_s1;
    logic             sign1_q;
    logic [MAG_W-1:0] mag1_q;

    always_comb begin
        neg_s1 = -bus.in_data;
        if (!bus.in_data[IN_W-1]) begin
            mag_s1 = bus.in_data[MAG_W-1:0];
        end else if (neg_s1[IN_W-1]) begin
            // Only the most negative input still has its top bit set after negation.
            mag_s1 = '1;
        end else begin
            mag_s1 = neg_s1[MAG_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            mag1_q  <= '0;
        end else if (rdy1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                sign1_q <= bus.in_data[IN_W-1];
                mag1_q  <= mag_s1;
            end
        end
    end

    // ---------------- S2: normalise ----------------
    logic [IDX_W-1:0] lod_idx;
    logic             lod_zero;
    logic [31:0]      p_s2, e_s2;
    logic [X_W-1:0]   mag_x, sh_s2, sh_rnd;
    logic [SIG_W-1:0] f_s2;
    logic             rnd_s2;
    logic             sign2_q, rnd2_q;
    logic [E_W-1:0]   e2_q;
    logic [SIG_W-1:0] f2_q;

    fpcvt_lod #(
        .MAG_W (MAG_W),
        .IDX_W (IDX_W)
    ) u_lod (
        .mag  (mag1_q),
        .idx  (lod_idx),
        .zero (lod_zero)
    );

    always_comb begin
        p_s2   = lod_zero ? 32'd0 : 32'(lod_idx);
        e_s2   = (p_s2 < SIG_W) ? 32'd0 : p_s2 - (SIG_W - 1);
        mag_x  = X_W'(mag1_q);
        sh_s2  = mag_x >> e_s2;
        f_s2   = sh_s2[SIG_W-1:0];
        sh_rnd = '0;
        rnd_s2 = 1'b0;
        if (e_s2 != 32'd0) begin
            // Rounding bit is the first bit shifted out.
            sh_rnd = mag_x >> (e_s2 - 32'd1);
            rnd_s2 = sh_rnd[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            e2_q    <= '0;
            f2_q    <= '0;
            rnd2_q  <= 1'b0;
        end else if (rdy2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sign2_q <= sign1_q;
                e2_q    <= E_W'(e_s2);
                f2_q    <= f_s2;
                rnd2_q  <= rnd_s2;
            end
        end
    end

    // ---------------- S3: round, saturate, pack ----------------
    logic [SIG_W:0]   f_sum;
    logic [SIG_W-1:0] f_rnd, sig_s3;
    logic [E_W:0]     e_rnd;
    logic [EXP_W-1:0] exp_s3;
    logic             sat_s3;
    logic [OUT_W-1:0] data3_q;
    logic             sat3_q;

    always_comb begin
        f_sum = {1'b0, f2_q} + (SIG_W + 1)'(rnd2_q);
        f_rnd = f_sum[SIG_W-1:0];
        e_rnd = {1'b0, e2_q};
        if (f_sum[SIG_W]) begin
            // Round carry: 2^SIG_W * 2^E == 2^(SIG_W-1) * 2^(E+1).
            f_rnd          = '0;
            f_rnd[SIG_W-1] = 1'b1;
            e_rnd          = {1'b0, e2_q} + 1'b1;
        end
        if (32'(e_rnd) > EXP_MAX) begin
            sat_s3 = 1'b1;
            exp_s3 = '1;
            sig_s3 = '1;
        end else begin
            sat_s3 = 1'b0;
            exp_s3 = EXP_W'(e_rnd);
            sig_s3 = f_rnd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q    <= 1'b0;
            data3_q <= '0;
            sat3_q  <= 1'b0;
        end else if (rdy3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                data3_q <= {sign2_q, exp_s3, sig_s3};
                sat3_q  <= sat_s3;
            end
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.out_data  = data3_q;
    assign bus.out_sat   = sat3_q;

`ifdef FPCVT_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (v3_q && bus.out_ready && sat3_q && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`endif

endmodule
